// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
//   state_t       : controller FSM state encoding
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used as the serial datapath of the adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: computes op_a + op_b + carry_in one bit per cycle, LSB
// first, through a single full-adder cell with a registered carry.
// Ports:
//   clk, rstn           : clock, synchronous active-low reset
//   start, abort        : begin a new addition / cancel the running one
//   op_a, op_b, carry_in: operands, sampled only when start is accepted
//   busy, done          : RUN-state flag, one-cycle result-valid pulse
//   sum, carry_out, ovf : result, final carry, signed overflow (held)
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             bit_s;
    logic             bit_c;
    logic             last_bit;

    // Single full adder fed from the LSBs of the shift registers.
    fa_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (bit_s),
        .cout(bit_c)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Controller FSM and datapath. The sum bits shift into the top of a_sh as
    // operand bits leave the bottom, so a_sh doubles as the result register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    // abort is irrelevant here; start alone decides
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        carry <= carry_in;
                        cnt   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        a_sh  <= {bit_s, a_sh[WIDTH-1:1]};
                        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                        carry <= bit_c;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_bit) begin
                            // carry currently holds the carry into the MSB
                            sum       <= {bit_s, a_sh[WIDTH-1:1]};
                            carry_out <= bit_c;
                            ovf       <= carry ^ bit_c;
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed scenarios then
// randomized start/abort/reset traffic checked against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W  = 8;
    localparam int W1 = W + 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         abort;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         ovf;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .abort    (abort),
        .op_a     (op_a),
        .op_b     (op_b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out),
        .ovf      (ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t held;
    exp_t cur;
    int   cyc;
    int   m_k;
    bit   m_active;
    bit   busy_e;
    bit   done_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Plain arithmetic reference: signed overflow when both operands share a
    // sign and the result sign differs.
    function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci);
        logic [W:0] full;
        exp_t       r;
        full  = W1'(a) + W1'(b) + W1'(ci);
        r.s   = full[W-1:0];
        r.c   = full[W];
        r.v   = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        r.due = 0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an accepted addition occupies edges k+1..k+W; the
    // result appears after edge k+W. Expected results go into the queue.
    initial begin
        cyc      = 0;
        m_k      = 0;
        m_active = 1'b0;
        busy_e   = 1'b0;
        done_e   = 1'b0;
        held     = '{s: '0, c: 1'b0, v: 1'b0, due: 0};
        cur      = held;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                m_active = 1'b0;
                q.delete();
                held   = '{s: '0, c: 1'b0, v: 1'b0, due: 0};
                busy_e = 1'b0;
                done_e = 1'b0;
            end else if (m_active && cyc > m_k && cyc <= m_k + W) begin
                if (abort) begin
                    m_active = 1'b0;
                    if (q.size() > 0) q.delete(q.size() - 1);
                    busy_e = 1'b0;
                    done_e = 1'b0;
                end else if (cyc == m_k + W) begin
                    held     = cur;
                    m_active = 1'b0;
                    busy_e   = 1'b0;
                    done_e   = 1'b1;
                end else begin
                    busy_e = 1'b1;
                    done_e = 1'b0;
                end
            end else begin
                done_e = 1'b0;
                if (start) begin
                    cur      = ref_add(op_a, op_b, carry_in);
                    cur.due  = cyc + W;
                    q.push_back(cur);
                    m_active = 1'b1;
                    m_k      = cyc;
                    busy_e   = 1'b1;
                end else begin
                    busy_e = 1'b0;
                end
            end
        end
    end

    // Monitor: pops on every done pulse and checks flags/held outputs each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_has_entry", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("res_sum", 64'(sum), 64'(e.s));
                    check("res_carry_out", 64'(carry_out), 64'(e.c));
                    check("res_ovf", 64'(ovf), 64'(e.v));
                    check("done_cycle", 64'(cyc), 64'(e.due));
                end
            end
            check("done", 64'(done), 64'(done_e));
            check("busy", 64'(busy), 64'(busy_e));
            check("held_sum", 64'(sum), 64'(held.s));
            check("held_carry_out", 64'(carry_out), 64'(held.c));
            check("held_ovf", 64'(ovf), 64'(held.v));
        end
    end

    // Apply one cycle of inputs; they stay stable across the next rising edge.
    task automatic drive(input logic st, input logic ab, input logic rn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        start    = st;
        abort    = ab;
        rstn     = rn;
        op_a     = a;
        op_b     = b;
        carry_in = ci;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    initial begin
        // reset
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(2);

        // basic additions, carry and overflow corners
        drive(1'b1, 1'b0, 1'b1, 8'h0F, 8'h01, 1'b0);
        idle(11);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
        idle(11);
        drive(1'b1, 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
        idle(11);
        drive(1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1);
        idle(11);

        // start during RUN is ignored
        drive(1'b1, 1'b0, 1'b1, 8'h03, 8'h04, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, 8'hAA, 8'h55, 1'b0);
        idle(10);

        // start held high: back-to-back additions
        drive(1'b1, 1'b0, 1'b1, 8'h21, 8'h12, 1'b0);
        for (int i = 0; i < W; i++)
            drive(1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'hC8, 8'h64, 1'b1);
        idle(12);

        // abort mid-run keeps the previous result
        drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0);
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        idle(10);

        // abort together with start in DONE: start wins
        drive(1'b1, 1'b0, 1'b1, 8'h05, 8'h06, 1'b0);
        idle(W);
        drive(1'b1, 1'b1, 1'b1, 8'h90, 8'h90, 1'b0);
        idle(11);

        // reset mid-run clears everything
        drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(10);

        // random traffic
        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 199) != 0),
                  W'($urandom), W'($urandom), 1'($urandom));

        idle(W + 3);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
